// File: rtl/memory_requester_pkg.sv
// Shared types and sizing helpers for the memory requester and its wait counter.
package mem_req_pkg;

    // Transaction phases of the requester.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        WAIT_RD = 3'd3,
        WAIT_WR = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Wait counter width: wide enough to hold the larger of the two wait limits,
    // with one spare bit so the post-limit increment never wraps.
    function automatic int cnt_width(input int timeout, input int write_hold);
        int largest;
        largest = (timeout > write_hold) ? timeout : write_hold;
        return $clog2(largest) + 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(16, 2);

endpackage

// File: rtl/memory_requester_if.sv
// Signal bundle between the requester (master) and an unclocked word memory (slave).
interface memory_requester_if #(
    parameter int WORD_SIZE = 32
);
    logic                 mem_start;
    logic                 mem_write_enabled;
    logic [WORD_SIZE-1:0] mem_address;
    logic [WORD_SIZE-1:0] mem_input_data;
    logic                 mem_valid;
    logic [WORD_SIZE-1:0] mem_output_data;
    logic                 mem_err_invalid_address;

    modport master (
        output mem_start, mem_write_enabled, mem_address, mem_input_data,
        input  mem_valid, mem_output_data, mem_err_invalid_address
    );

    modport slave (
        input  mem_start, mem_write_enabled, mem_address, mem_input_data,
        output mem_valid, mem_output_data, mem_err_invalid_address
    );
endinterface

// File: rtl/memory_requester_wait_counter.sv
// Clear/enable up-counter with a terminal compare against a run-time limit.
module wait_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);
    logic [CNT_W-1:0] count;

    // Count enabled cycles; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);
endmodule

// File: rtl/memory_requester.sv
// Synchronous initiator for the unclocked word memory: one load/store at a time,
// address/data held stable around the mem_start rising edge, done/err reported.
module memory_requester
    import mem_req_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int MEMORY_SIZE = 1024,
    parameter int WRITE_HOLD  = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 req_write,
    input  logic [WORD_SIZE-1:0] req_address,
    input  logic [WORD_SIZE-1:0] req_data,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 err,
    memory_requester_if.master   mem
);
    localparam int               CNT_W    = cnt_width(TIMEOUT, WRITE_HOLD);
    localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WR_LIMIT = CNT_W'(WRITE_HOLD - 1);

    state_t           state;
    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_limit;
    logic             cnt_at_limit;
    logic             addr_bad;

    // The counter restarts in STROBE; on a read it only advances while data is absent.
    assign cnt_clear = (state == STROBE);
    assign cnt_en    = ((state == WAIT_RD) && !mem.mem_valid) || (state == WAIT_WR);
    assign cnt_limit = (state == WAIT_WR) ? WR_LIMIT : RD_LIMIT;

    // The memory's own decode is authoritative; the local bound guards a mis-sized instance.
    assign addr_bad = mem.mem_err_invalid_address ||
                      (mem.mem_address >= WORD_SIZE'(MEMORY_SIZE));

    wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .limit    (cnt_limit),
        .at_limit (cnt_at_limit)
    );

    // Transaction FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            err                   <= 1'b0;
            rd_data               <= '0;
            mem.mem_start         <= 1'b0;
            mem.mem_write_enabled <= 1'b0;
            mem.mem_address       <= '0;
            mem.mem_input_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mem.mem_write_enabled <= req_write;
                        mem.mem_address       <= req_address;
                        mem.mem_input_data    <= req_data;
                        busy                  <= 1'b1;
                        state                 <= SETUP;
                    end
                end
                SETUP: begin
                    if (addr_bad) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem.mem_start <= 1'b1;
                        state         <= STROBE;
                    end
                end
                STROBE: begin
                    // mem_valid may still be high from the previous read, so it is not looked at here.
                    state <= mem.mem_write_enabled ? WAIT_WR : WAIT_RD;
                end
                WAIT_RD: begin
                    if (mem.mem_valid) begin
                        rd_data       <= mem.mem_output_data;
                        done          <= 1'b1;
                        err           <= 1'b0;
                        mem.mem_start <= 1'b0;
                        state         <= DONE;
                    end else if (cnt_at_limit) begin
                        done          <= 1'b1;
                        err           <= 1'b1;
                        mem.mem_start <= 1'b0;
                        state         <= DONE;
                    end
                end
                WAIT_WR: begin
                    if (cnt_at_limit) begin
                        done          <= 1'b1;
                        err           <= 1'b0;
                        mem.mem_start <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_requester.sv
// Bench for memory_requester: behavioural word memory plus stubs, reference model in arrays.
module tb_memory_requester;
    localparam int WS = 32;
    localparam int MS = 1024;
    localparam int WH = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          req_write;
    logic [WS-1:0] req_address;
    logic [WS-1:0] req_data;
    logic          busy;
    logic          done;
    logic [WS-1:0] rd_data;
    logic          err;

    memory_requester_if #(.WORD_SIZE(WS)) bus ();

    memory_requester #(
        .WORD_SIZE(WS), .MEMORY_SIZE(MS), .WRITE_HOLD(WH), .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_write   (req_write),
        .req_address (req_address),
        .req_data    (req_data),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data),
        .err         (err),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mode   = 0;   // 0 real memory, 1 never valid, 2 stale-valid stub
    int          start_count = 0;
    logic [31:0] mem_array [MS];
    logic [31:0] ref_mem   [MS];
    logic [31:0] exp_rd;

    assign bus.mem_err_invalid_address = (bus.mem_address >= 32'(MS));

    // Memory / stub behaviour, acting on the rising edge of mem_start.
    always @(posedge bus.mem_start) begin
        logic [31:0] a;
        a = bus.mem_address;
        start_count++;
        if (bus.mem_write_enabled) begin
            if (a < 32'(MS)) mem_array[a[9:0]] = bus.mem_input_data;
            bus.mem_valid = 1'b0;
        end else if (mode == 0) begin
            bus.mem_valid = 1'b0;
            #1;
            bus.mem_output_data = (a < 32'(MS)) ? mem_array[a[9:0]] : 32'h0;
            bus.mem_valid = 1'b1;
        end else if (mode == 1) begin
            bus.mem_valid = 1'b0;
        end else begin
            bus.mem_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus.mem_output_data = 32'hA5A5A5A5;
            bus.mem_valid = 1'b1;
        end
    end

    // Drives one request and waits (bounded) for done; reports what was observed.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic got_done, output logic got_err,
                          output int starts, output logic strobe_prev, output logic strobe_now);
        int base;
        @(posedge clk); #1;
        req = 1'b1; req_write = w; req_address = a; req_data = d;
        base = start_count;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        strobe_prev = bus.mem_start;
        while (done !== 1'b1 && lat < 40) begin
            strobe_prev = bus.mem_start;
            @(posedge clk); #1;
            lat++;
        end
        got_done   = (done === 1'b1);
        got_err    = err;
        starts     = start_count - base;
        strobe_now = bus.mem_start;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, bus.mem_start, bus.mem_write_enabled} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, done, err, bus.mem_start, bus.mem_write_enabled});
        end
        checks++;
        if ({rd_data, bus.mem_address, bus.mem_input_data} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got rd=%h addr=%h wd=%h want 0", rd_data, bus.mem_address, bus.mem_input_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int lat, st; logic gd, ge, sp, sn;
        mode = 0;
        do_txn(1'b1, 32'd5, 32'hDEADBEEF, lat, gd, ge, st, sp, sn);
        ref_mem[5] = 32'hDEADBEEF;
        checks++;
        if (!gd || lat != 3 + WH || ge !== 1'b0) begin
            errors++; $display("FAIL store_done got done=%0d lat=%0d err=%b want 1 %0d 0", gd, lat, ge, 3 + WH);
        end
        checks++;
        if (st != 1) begin errors++; $display("FAIL store_strobes got %0d want 1", st); end
        do_txn(1'b0, 32'd5, 32'h0, lat, gd, ge, st, sp, sn);
        exp_rd = ref_mem[5];
        checks++;
        if (!gd || lat != 4 || ge !== 1'b0) begin
            errors++; $display("FAIL load_done got done=%0d lat=%0d err=%b want 1 4 0", gd, lat, ge);
        end
        checks++;
        if (rd_data !== exp_rd) begin errors++; $display("FAIL load_data got %h want %h", rd_data, exp_rd); end
        checks++;
        if (st != 1) begin errors++; $display("FAIL load_strobes got %0d want 1", st); end
    endtask

    task automatic test_out_of_range();
        int lat, st; logic gd, ge, sp, sn;
        logic [31:0] bad [2];
        bad[0] = 32'd1024;
        bad[1] = 32'hFFFFFFFF;
        mode = 0;
        for (int i = 0; i < 2; i++) begin
            do_txn(1'b0, bad[i], 32'h0, lat, gd, ge, st, sp, sn);
            checks++;
            if (!gd || lat != 2 || ge !== 1'b1) begin
                errors++; $display("FAIL range_done addr=%h got done=%0d lat=%0d err=%b want 1 2 1", bad[i], gd, lat, ge);
            end
            checks++;
            if (st != 0 || rd_data !== exp_rd) begin
                errors++; $display("FAIL range_side got strobes=%0d rd=%h want 0 %h", st, rd_data, exp_rd);
            end
        end
    endtask

    task automatic test_boundary();
        int lat, st; logic gd, ge, sp, sn;
        mode = 0;
        do_txn(1'b1, 32'd1023, 32'h12345678, lat, gd, ge, st, sp, sn);
        ref_mem[1023] = 32'h12345678;
        checks++;
        if (!gd || ge !== 1'b0 || st != 1) begin
            errors++; $display("FAIL boundary_store got done=%0d err=%b strobes=%0d want 1 0 1", gd, ge, st);
        end
        do_txn(1'b0, 32'd1023, 32'h0, lat, gd, ge, st, sp, sn);
        exp_rd = ref_mem[1023];
        checks++;
        if (!gd || ge !== 1'b0 || rd_data !== exp_rd) begin
            errors++; $display("FAIL boundary_load got done=%0d err=%b rd=%h want 1 0 %h", gd, ge, rd_data, exp_rd);
        end
    endtask

    task automatic test_timeout();
        int lat, st; logic gd, ge, sp, sn;
        mode = 1;
        do_txn(1'b0, 32'd0, 32'h0, lat, gd, ge, st, sp, sn);
        checks++;
        if (!gd || lat != 3 + TO || ge !== 1'b1) begin
            errors++; $display("FAIL timeout_done got done=%0d lat=%0d err=%b want 1 %0d 1", gd, lat, ge, 3 + TO);
        end
        checks++;
        if (rd_data !== exp_rd) begin errors++; $display("FAIL timeout_rd got %h want %h", rd_data, exp_rd); end
        checks++;
        if (sp !== 1'b1 || sn !== 1'b0) begin
            errors++; $display("FAIL timeout_strobe got before=%b at_done=%b want 1 0", sp, sn);
        end
    endtask

    task automatic test_stale_valid();
        int lat, st; logic gd, ge, sp, sn;
        mode = 0;
        do_txn(1'b0, 32'd5, 32'h0, lat, gd, ge, st, sp, sn);
        exp_rd = ref_mem[5];
        checks++;
        if (!gd || rd_data !== exp_rd) begin errors++; $display("FAIL stale_prep got rd=%h want %h", rd_data, exp_rd); end
        mode = 2;
        do_txn(1'b0, 32'd5, 32'h0, lat, gd, ge, st, sp, sn);
        exp_rd = 32'hA5A5A5A5;
        checks++;
        if (!gd || ge !== 1'b0 || rd_data !== exp_rd) begin
            errors++; $display("FAIL stale_valid got done=%0d err=%b rd=%h want 1 0 %h", gd, ge, rd_data, exp_rd);
        end
        mode = 0;
    endtask

    task automatic test_busy();
        int base, ndone, first;
        mode = 0;
        @(posedge clk); #1;
        req = 1'b1; req_write = 1'b1; req_address = 32'd7; req_data = 32'hCAFEF00D;
        base = start_count;
        @(posedge clk); #1; req = 1'b0;            // SETUP
        @(posedge clk); #1;                        // STROBE
        @(posedge clk); #1;                        // first write-hold cycle
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag got %b want 1", busy); end
        req = 1'b1; req_write = 1'b1; req_address = 32'd9; req_data = 32'h0BADF00D;
        ref_mem[7] = 32'hCAFEF00D;
        ndone = 0; first = -1;
        for (int c = 4; c < 16; c++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (ndone != 1 || first != 3 + WH) begin
            errors++; $display("FAIL busy_done got count=%0d at=%0d want 1 at %0d", ndone, first, 3 + WH);
        end
        checks++;
        if (start_count - base != 1) begin
            errors++; $display("FAIL busy_strobes got %0d want 1", start_count - base);
        end
    endtask

    task automatic test_reset_mid();
        int lat, st, ndone, nstart, base; logic gd, ge, sp, sn;
        mode = 1;
        @(posedge clk); #1;
        req = 1'b1; req_write = 1'b0; req_address = 32'd3; req_data = 32'h0;
        @(posedge clk); #1; req = 1'b0;            // SETUP
        @(posedge clk); #1;                        // STROBE
        @(posedge clk); #1;                        // WAIT_RD
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd = 32'h0;
        checks++;
        if ({busy, done, err, bus.mem_start, bus.mem_write_enabled} !== 5'b0 ||
            {rd_data, bus.mem_address, bus.mem_input_data} !== 96'h0) begin
            errors++;
            $display("FAIL midreset_outputs got ctrl=%b rd=%h addr=%h want all 0",
                     {busy, done, err, bus.mem_start, bus.mem_write_enabled}, rd_data, bus.mem_address);
        end
        ndone = 0; base = start_count;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        nstart = start_count - base;
        checks++;
        if (ndone != 0 || nstart != 0) begin
            errors++; $display("FAIL midreset_quiet got dones=%0d strobes=%0d want 0 0", ndone, nstart);
        end
        mode = 0;
        do_txn(1'b0, 32'd7, 32'h0, lat, gd, ge, st, sp, sn);
        exp_rd = ref_mem[7];
        checks++;
        if (!gd || lat != 4 || rd_data !== exp_rd) begin
            errors++; $display("FAIL midreset_after got done=%0d lat=%0d rd=%h want 1 4 %h", gd, lat, rd_data, exp_rd);
        end
    endtask

    task automatic test_random();
        int lat, st, sel, exp_lat; logic gd, ge, sp, sn, w, oor;
        logic [31:0] a, d;
        mode = 0;
        for (int n = 0; n < 30; n++) begin
            w   = 1'($urandom % 2);
            sel = int'($urandom % 6);
            if (sel == 0)      a = 32'(MS) + ($urandom % 4096);
            else if (sel == 1) a = 32'hFFFFFFFF;
            else               a = $urandom_range(0, MS - 1);
            d   = $urandom;
            oor = (a >= 32'(MS));
            exp_lat = oor ? 2 : (w ? 3 + WH : 4);
            if (!oor && w)  ref_mem[a[9:0]] = d;
            if (!oor && !w) exp_rd = ref_mem[a[9:0]];
            do_txn(w, a, d, lat, gd, ge, st, sp, sn);
            checks++;
            if (!gd || lat != exp_lat || ge !== oor || st != (oor ? 0 : 1)) begin
                errors++;
                $display("FAIL rand_txn n=%0d w=%b a=%h got done=%0d lat=%0d err=%b strobes=%0d want 1 %0d %b %0d",
                         n, w, a, gd, lat, ge, st, exp_lat, oor, oor ? 0 : 1);
            end
            checks++;
            if (rd_data !== exp_rd || bus.mem_address !== a) begin
                errors++;
                $display("FAIL rand_data n=%0d got rd=%h addr=%h want %h %h", n, rd_data, bus.mem_address, exp_rd, a);
            end
        end
    endtask

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_output_data = 32'h0;
        exp_rd = 32'h0;
        for (int i = 0; i < MS; i++) begin
            mem_array[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        test_reset();
        test_store_load();
        test_out_of_range();
        test_boundary();
        test_timeout();
        test_stale_valid();
        test_busy();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
